// File: rtl/ibuf_pkg.sv
// Shared definitions for the ibuf drain path: header layout, FSM encodings,
// beat record and the last-beat byte-enable helper.
package ibuf_pkg;

  localparam int LEN_MSB = 47;
  localparam int LEN_LSB = 32;

  localparam logic [4:0] ST_IDLE     = 5'b00001;
  localparam logic [4:0] ST_HDR_WAIT = 5'b00010;
  localparam logic [4:0] ST_HDR_DEC  = 5'b00100;
  localparam logic [4:0] ST_STREAM   = 5'b01000;
  localparam logic [4:0] ST_DRAIN    = 5'b10000;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  // A zero remainder means the final word is completely filled.
  function automatic logic [7:0] keep_from_rem(input logic [2:0] rem);
    logic [7:0] k;
    if (rem == 3'd0) begin
      k = 8'hFF;
    end else begin
      k = (8'h01 << rem) - 8'h01;
    end
    return k;
  endfunction

endpackage

// File: rtl/ibuf_rd_skid.sv
// Two-entry beat FIFO fed by ibuf reads; tracks the read in flight so the
// issue logic never overruns the two slots.
module ibuf_rd_skid
  import ibuf_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue,
  input  logic [7:0]  issue_keep,
  input  logic        issue_last,
  input  logic [63:0] rd_data,
  input  logic        ready,
  output logic        can_issue,
  output logic        valid,
  output beat_t       head
);

  logic       flight_r;
  logic [7:0] flight_keep_r;
  logic       flight_last_r;
  logic [1:0] count_r;
  logic [1:0] count_nx;
  logic       valid_r;
  beat_t      head_r;
  beat_t      tail_r;
  beat_t      head_nx;
  beat_t      tail_nx;
  beat_t      in_s;
  logic       push_s;
  logic       pop_s;
  logic [2:0] occ_s;

  assign push_s = flight_r;
  assign pop_s  = valid_r & ready;
  assign in_s   = {rd_data, flight_keep_r, flight_last_r};
  // Occupancy the slots will have after this cycle's pop, before any new issue.
  assign occ_s     = {1'b0, count_r} + {2'b00, flight_r} - {2'b00, pop_s};
  assign can_issue = (occ_s < 3'd2);
  assign valid     = valid_r;
  assign head      = head_r;

  // Next-state of the two storage slots.
  always_comb begin
    count_nx = count_r;
    head_nx  = head_r;
    tail_nx  = tail_r;
    case (count_r)
      2'd0: begin
        if (push_s) begin
          head_nx  = in_s;
          count_nx = 2'd1;
        end else begin
          count_nx = 2'd0;
        end
      end
      2'd1: begin
        if (push_s && pop_s) begin
          head_nx = in_s;
        end else if (push_s) begin
          tail_nx  = in_s;
          count_nx = 2'd2;
        end else if (pop_s) begin
          count_nx = 2'd0;
        end else begin
          count_nx = 2'd1;
        end
      end
      2'd2: begin
        if (pop_s) begin
          head_nx = tail_r;
          if (push_s) begin
            tail_nx  = in_s;
            count_nx = 2'd2;
          end else begin
            count_nx = 2'd1;
          end
        end else begin
          count_nx = 2'd2;
        end
      end
      default: begin
        count_nx = 2'd0;
      end
    endcase
  end

  // Storage, occupancy and in-flight tag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flight_r      <= 1'b0;
      flight_keep_r <= 8'h00;
      flight_last_r <= 1'b0;
      count_r       <= 2'd0;
      valid_r       <= 1'b0;
      head_r        <= '0;
      tail_r        <= '0;
    end else begin
      flight_r      <= issue;
      flight_keep_r <= issue_keep;
      flight_last_r <= issue_last;
      count_r       <= count_nx;
      valid_r       <= (count_nx != 2'd0);
      head_r        <= head_nx;
      tail_r        <= tail_nx;
    end
  end

endmodule

// File: rtl/ibuf_drain2axis.sv
// Replays packets committed to the ibuf as an AXI4-Stream master and returns
// consumed words via committed_cons. IBUF_DRAIN_STATS_EN adds packet/byte counters.
module ibuf_drain2axis
  import ibuf_pkg::*;
#(
  parameter int BW     = 10,
  parameter int RD_LAT = 1
) (
  input  logic          m_axis_aclk,
  input  logic          m_axis_aresetn,
  input  logic [BW:0]   committed_prod,
  output logic [BW:0]   committed_cons,
  output logic [BW-1:0] rd_addr,
  input  logic [63:0]   rd_data,
  output logic [63:0]   m_axis_tdata,
  output logic [7:0]    m_axis_tkeep,
  output logic          m_axis_tvalid,
  output logic          m_axis_tlast,
  input  logic          m_axis_tready
`ifdef IBUF_DRAIN_STATS_EN
  ,
  output logic [31:0]   pkt_cnt,
  output logic [47:0]   byte_cnt
`endif
);

  generate
    if (RD_LAT != 1) begin : g_rd_lat_check
      $error("ibuf_drain2axis supports RD_LAT == 1 only");
    end
  endgenerate

  logic [4:0]  state_r;
  logic [4:0]  state_nx;
  logic [BW:0] rd_ptr_r;
  logic [BW:0] cons_r;
  logic [BW:0] avail_s;
  logic        has_data_s;
  logic [13:0] nwords_r;
  logic [2:0]  rem_r;
  logic [13:0] issued_r;
  logic [13:0] issued_nx;
  logic        issue_s;
  logic        data_issue_s;
  logic        issue_last_s;
  logic [7:0]  issue_keep_s;
  logic        hdr_rel_s;
  logic        can_issue_s;
  logic        valid_s;
  beat_t       head_s;
  logic        hs_s;
  logic        last_hs_s;
  logic [16:0] len_plus7_s;

  assign avail_s      = committed_prod - rd_ptr_r;
  assign has_data_s   = (avail_s != {(BW+1){1'b0}});
  assign rd_addr      = rd_ptr_r[BW-1:0];
  assign hs_s         = valid_s & m_axis_tready;
  assign last_hs_s    = hs_s & head_s.last;
  assign issue_keep_s = issue_last_s ? keep_from_rem(rem_r) : 8'hFF;
  assign len_plus7_s  = {1'b0, rd_data[LEN_MSB:LEN_LSB]} + 17'd7;

  // Packet sequencing and read-issue decision.
  always_comb begin
    state_nx     = state_r;
    issue_s      = 1'b0;
    data_issue_s = 1'b0;
    issue_last_s = 1'b0;
    hdr_rel_s    = 1'b0;
    issued_nx    = issued_r;
    case (state_r)
      ST_IDLE: begin
        if (has_data_s) begin
          issue_s  = 1'b1;
          state_nx = ST_HDR_WAIT;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_HDR_WAIT: begin
        state_nx = ST_HDR_DEC;
      end
      ST_HDR_DEC: begin
        hdr_rel_s = 1'b1;
        issued_nx = 14'd0;
        if (nwords_r == 14'd0) begin
          state_nx = ST_IDLE;
        end else if (has_data_s && can_issue_s) begin
          // First data read overlaps decode to keep the inter-packet gap short.
          issue_s      = 1'b1;
          data_issue_s = 1'b1;
          issue_last_s = (nwords_r == 14'd1);
          issued_nx    = 14'd1;
          state_nx     = (nwords_r == 14'd1) ? ST_DRAIN : ST_STREAM;
        end else begin
          state_nx = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (has_data_s && can_issue_s && (issued_r < nwords_r)) begin
          issue_s      = 1'b1;
          data_issue_s = 1'b1;
          issue_last_s = ((issued_r + 14'd1) == nwords_r);
          issued_nx    = issued_r + 14'd1;
          state_nx     = ((issued_r + 14'd1) == nwords_r) ? ST_DRAIN : ST_STREAM;
        end else begin
          state_nx = ST_STREAM;
        end
      end
      ST_DRAIN: begin
        if (last_hs_s && has_data_s) begin
          issue_s  = 1'b1;
          state_nx = ST_HDR_WAIT;
        end else if (last_hs_s) begin
          state_nx = ST_IDLE;
        end else begin
          state_nx = ST_DRAIN;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // FSM, pointers and latched header fields.
  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      state_r  <= ST_IDLE;
      rd_ptr_r <= {(BW+1){1'b0}};
      cons_r   <= {(BW+1){1'b0}};
      nwords_r <= 14'd0;
      rem_r    <= 3'd0;
      issued_r <= 14'd0;
    end else begin
      state_r  <= state_nx;
      issued_r <= issued_nx;
      rd_ptr_r <= rd_ptr_r + {{BW{1'b0}}, issue_s};
      cons_r   <= cons_r + {{BW{1'b0}}, hdr_rel_s} + {{BW{1'b0}}, hs_s};
      if (state_r == ST_HDR_WAIT) begin
        nwords_r <= len_plus7_s[16:3];
        rem_r    <= rd_data[LEN_LSB+2:LEN_LSB];
      end else begin
        nwords_r <= nwords_r;
        rem_r    <= rem_r;
      end
    end
  end

  ibuf_rd_skid u_skid (
    .clk        (m_axis_aclk),
    .rst_n      (m_axis_aresetn),
    .issue      (data_issue_s),
    .issue_keep (issue_keep_s),
    .issue_last (issue_last_s),
    .rd_data    (rd_data),
    .ready      (m_axis_tready),
    .can_issue  (can_issue_s),
    .valid      (valid_s),
    .head       (head_s)
  );

  assign committed_cons = cons_r;
  assign m_axis_tvalid  = valid_s;
  assign m_axis_tdata   = head_s.data;
  assign m_axis_tkeep   = head_s.keep;
  assign m_axis_tlast   = head_s.last;

`ifdef IBUF_DRAIN_STATS_EN
  logic [15:0] len_r;
  logic [31:0] pkt_cnt_r;
  logic [47:0] byte_cnt_r;

  // Per-packet length and running totals, updated on each tlast handshake.
  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      len_r      <= 16'd0;
      pkt_cnt_r  <= 32'd0;
      byte_cnt_r <= 48'd0;
    end else begin
      if (state_r == ST_HDR_WAIT) begin
        len_r <= rd_data[LEN_MSB:LEN_LSB];
      end else begin
        len_r <= len_r;
      end
      if (last_hs_s) begin
        pkt_cnt_r  <= pkt_cnt_r + 32'd1;
        byte_cnt_r <= byte_cnt_r + {32'd0, len_r};
      end else begin
        pkt_cnt_r  <= pkt_cnt_r;
        byte_cnt_r <= byte_cnt_r;
      end
    end
  end

  assign pkt_cnt  = pkt_cnt_r;
  assign byte_cnt = byte_cnt_r;
`endif

endmodule

// File: tb/tb_ibuf_drain2axis.sv
// Self-checking bench: ibuf RAM + writer model, randomized packets and tready,
// scoreboard of expected beats derived from packet lengths.
module tb_ibuf_drain2axis;

  localparam int BW    = 4;
  localparam int DEPTH = 16;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } exp_beat_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [BW:0]   committed_prod;
  logic [BW:0]   committed_cons;
  logic [BW-1:0] rd_addr;
  logic [63:0]   rd_data;
  logic [63:0]   m_axis_tdata;
  logic [7:0]    m_axis_tkeep;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tready;
`ifdef IBUF_DRAIN_STATS_EN
  logic [31:0]   pkt_cnt;
  logic [47:0]   byte_cnt;
`endif

  always #5 clk = ~clk;

  ibuf_drain2axis #(.BW(BW), .RD_LAT(1)) dut (
    .m_axis_aclk    (clk),
    .m_axis_aresetn (rst_n),
    .committed_prod (committed_prod),
    .committed_cons (committed_cons),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tkeep   (m_axis_tkeep),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tready  (m_axis_tready)
`ifdef IBUF_DRAIN_STATS_EN
    ,
    .pkt_cnt        (pkt_cnt),
    .byte_cnt       (byte_cnt)
`endif
  );

  logic [63:0] mem [0:DEPTH-1];
  logic [63:0] wq [$];
  exp_beat_t   exp_q [$];
  logic [BW:0] wr_ptr;
  logic [BW:0] used;
  logic [63:0] w_tmp;
  int          lag_cnt;
  bit          lag = 1'b0;
  bit          rand_ready = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          beats_seen = 0;
  int          first_cyc = 0;
  int          last_cyc = 0;
  bit          in_pkt = 1'b0;
  bit          stall_prev = 1'b0;
  exp_beat_t   prev_b;
  logic [BW:0] exp_cons = '0;
  longint      exp_pkts = 0;
  longint      exp_bytes = 0;

  assign committed_prod = wr_ptr;
  assign used = wr_ptr - committed_cons;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // ibuf RAM with one-cycle read latency, plus a writer that respects free space.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      lag_cnt <= 0;
    end else begin
      rd_data <= mem[rd_addr];
      lag_cnt <= lag_cnt + 1;
      if (wq.size() != 0 && used < 5'(DEPTH) && (!lag || (lag_cnt % 4) == 0)) begin
        w_tmp = wq.pop_front();
        mem[wr_ptr[BW-1:0]] <= w_tmp;
        wr_ptr <= wr_ptr + 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    #1;
    if (rand_ready) m_axis_tready = ($urandom % 2) == 0;
  end

  // Output monitor: stall stability and scoreboard comparison on handshake.
  always @(negedge clk) begin
    exp_beat_t e;
    if (rst_n) begin
      if (stall_prev) begin
        check("stall_valid", {63'd0, m_axis_tvalid}, 64'd1);
        check("stall_data", m_axis_tdata, prev_b.d);
        check("stall_keep", {56'd0, m_axis_tkeep}, {56'd0, prev_b.k});
        check("stall_last", {63'd0, m_axis_tlast}, {63'd0, prev_b.l});
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("tdata", m_axis_tdata, e.d);
          check("tkeep", {56'd0, m_axis_tkeep}, {56'd0, e.k});
          check("tlast", {63'd0, m_axis_tlast}, {63'd0, e.l});
          beats_seen++;
          if (!in_pkt) first_cyc = cyc;
          in_pkt = 1'b1;
          if (e.l) begin
            last_cyc = cyc;
            in_pkt   = 1'b0;
          end
        end
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      prev_b.d = m_axis_tdata;
      prev_b.k = m_axis_tkeep;
      prev_b.l = m_axis_tlast;
    end else begin
      stall_prev = 1'b0;
      in_pkt     = 1'b0;
    end
  end

  task automatic send_pkt(input int len);
    logic [63:0] h;
    logic [63:0] d;
    int nw;
    int bytes;
    exp_beat_t b;
    h = {$urandom, $urandom};
    h[47:32] = 16'(len);
    wq.push_back(h);
    nw = (len + 7) / 8;
    for (int i = 0; i < nw; i++) begin
      d = {$urandom, $urandom};
      wq.push_back(d);
      bytes = (i == nw - 1) ? (len - 8 * (nw - 1)) : 8;
      b.d = d;
      b.k = (bytes == 8) ? 8'hFF : 8'((1 << bytes) - 1);
      b.l = (i == nw - 1);
      exp_q.push_back(b);
    end
    exp_cons = exp_cons + (BW+1)'(1 + nw);
    if (nw != 0) exp_pkts++;
    exp_bytes += len;
  endtask

  task automatic wait_drain(input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (wq.size() == 0 && exp_q.size() == 0) break;
    end
    repeat (6) @(posedge clk);
    @(negedge clk);
    check({tag, "_drained"}, {63'd0, (wq.size() == 0 && exp_q.size() == 0)}, 64'd1);
    check({tag, "_cons"}, 64'(committed_cons), 64'(exp_cons));
  endtask

  initial begin
    int b0;
    rst_n = 1'b0;
    m_axis_tready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cons", 64'(committed_cons), 64'd0);
    check("rst_rd_addr", 64'(rd_addr), 64'd0);
    check("rst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
    check("rst_tlast", {63'd0, m_axis_tlast}, 64'd0);
    check("rst_tkeep", {56'd0, m_axis_tkeep}, 64'd0);
    check("rst_tdata", m_axis_tdata, 64'd0);
    rst_n = 1'b1;

    send_pkt(64);
    wait_drain(500, "len64");
    check("len64_cons9", 64'(committed_cons), 64'd9);
    check("len64_contig", 64'(last_cyc - first_cyc), 64'd7);

    send_pkt(61);
    wait_drain(500, "len61");
    check("len61_contig", 64'(last_cyc - first_cyc), 64'd7);

    b0 = beats_seen;
    send_pkt(0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("len0_cons", 64'(committed_cons), 64'(exp_cons));
    check("len0_no_beat", 64'(beats_seen - b0), 64'd0);
    send_pkt(8);
    wait_drain(500, "len8");
    check("len8_beats", 64'(beats_seen - b0), 64'd1);

    send_pkt(20);
    send_pkt(100);
    send_pkt(3);
    send_pkt(130);
    wait_drain(2000, "wrap");

    rand_ready = 1'b1;
    for (int p = 0; p < 100; p++) send_pkt($urandom_range(1, 1518));
    wait_drain(60000, "random");
    rand_ready = 1'b0;
    #2 m_axis_tready = 1'b1;

`ifdef IBUF_DRAIN_STATS_EN
    check("pkt_cnt", 64'(pkt_cnt), 64'(exp_pkts[31:0]));
    check("byte_cnt", 64'(byte_cnt), 64'(exp_bytes[47:0]));
`endif

    lag = 1'b1;
    b0 = beats_seen;
    send_pkt(200);
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      if (beats_seen >= b0 + 10) break;
    end
    @(negedge clk);
    check("lag_progress", {63'd0, (beats_seen >= b0 + 10)}, 64'd1);
    check("lag_pending", {63'd0, (exp_q.size() != 0)}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_cons", 64'(committed_cons), 64'd0);
    check("mid_rst_rd_addr", 64'(rd_addr), 64'd0);
    check("mid_rst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
    check("mid_rst_tlast", {63'd0, m_axis_tlast}, 64'd0);
    check("mid_rst_tkeep", {56'd0, m_axis_tkeep}, 64'd0);
    check("mid_rst_tdata", m_axis_tdata, 64'd0);
    wq.delete();
    exp_q.delete();
    exp_cons  = '0;
    exp_pkts  = 0;
    exp_bytes = 0;
    lag = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    send_pkt(16);
    wait_drain(500, "post_rst");
    check("post_rst_cons3", 64'(committed_cons), 64'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
